// File: rtl/f_pc_seq_if.sv
// f_pc_seq_if: redirect/PC-control bundle between the F-stage sequencer and its neighbours
interface f_pc_seq_if;
  logic [31:0] F_PC;
  logic        stall;
  logic        br_valid;
  logic [31:0] br_target;
  logic        exc_req;
  logic        eret_req;
  logic [31:0] epc;
  logic [31:0] NPC;
  logic        PC_WE;
  logic        Req;
  logic        flush_fd;
  logic        busy;
  logic        pend_valid;
  modport master (
    output F_PC, stall, br_valid, br_target, exc_req, eret_req, epc,
    input  NPC, PC_WE, Req, flush_fd, busy, pend_valid
  );
  modport slave (
    input  F_PC, stall, br_valid, br_target, exc_req, eret_req, epc,
    output NPC, PC_WE, Req, flush_fd, busy, pend_valid
  );
endinterface

// File: rtl/f_pc_seq.sv
// f_pc_seq: next-PC selection with exception hold and stalled-branch buffering
module f_pc_seq #(
  parameter logic [31:0] EXC_PC   = 32'h0000_4180,
  parameter logic [3:0]  EXC_HOLD = 4'd2
) (
  input logic        CLK,
  input logic        RESET,
  f_pc_seq_if.slave  bus
);
  typedef enum logic {RUN, HOLD} state_t;
  state_t      state;
  logic [3:0]  cnt;
  logic        pend_valid;
  logic [31:0] pend_target;
  logic [31:0] seq_pc, npc;
  logic        we, req, flush;
  assign seq_pc = bus.F_PC + 32'd4;
  // next-PC source select; everything is quiet while reset is held
  always_comb begin
    npc = seq_pc;
    we = 1'b0;
    req = 1'b0;
    flush = 1'b0;
    if (!RESET) begin
      npc = seq_pc;
    end else if (state == HOLD) begin
      flush = 1'b1;
      req = bus.exc_req;
      we = bus.exc_req;
      npc = bus.exc_req ? EXC_PC : seq_pc;
    end else if (bus.exc_req) begin
      req = 1'b1;
      we = 1'b1;
      flush = 1'b1;
      npc = EXC_PC;
    end else if (bus.eret_req) begin
      we = 1'b1;
      flush = 1'b1;
      npc = bus.epc;
    end else if (!bus.stall) begin
      we = 1'b1;
      npc = pend_valid ? pend_target : bus.br_valid ? bus.br_target : seq_pc;
    end
  end
  assign bus.NPC = npc;
  assign bus.PC_WE = we;
  assign bus.Req = req;
  assign bus.flush_fd = flush;
  assign bus.busy = (state == HOLD);
  assign bus.pend_valid = pend_valid;
  // hold FSM and pending-redirect buffer; the oldest stalled branch wins
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state <= RUN;
      cnt <= 4'd0;
      pend_valid <= 1'b0;
      pend_target <= 32'd0;
    end else if (bus.exc_req) begin
      state <= HOLD;
      cnt <= EXC_HOLD;
      pend_valid <= 1'b0;
    end else if (state == HOLD) begin
      state <= (cnt == 4'd1) ? RUN : HOLD;
      cnt <= cnt - 4'd1;
    end else if (bus.eret_req) begin
      pend_valid <= 1'b0;
    end else if (bus.stall) begin
      if (bus.br_valid && !pend_valid) begin
        pend_valid <= 1'b1;
        pend_target <= bus.br_target;
      end
    end else begin
      pend_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_f_pc_seq.sv
// tb_f_pc_seq: directed vectors for the next-PC sequencer
module tb_f_pc_seq;
  logic CLK = 1'b0;
  logic RESET = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  f_pc_seq_if bus();
  f_pc_seq dut (.CLK(CLK), .RESET(RESET), .bus(bus));
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask
  task automatic idle();
    bus.stall = 0; bus.br_valid = 0; bus.br_target = 0;
    bus.exc_req = 0; bus.eret_req = 0;
  endtask
  initial begin
    bus.F_PC = 32'h3000; bus.epc = 32'h3100;
    idle();
    #2;
    chk("rst_we", bus.PC_WE, 0);
    chk("rst_npc", bus.NPC, 32'h3004);
    chk("rst_pend", bus.pend_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_req", bus.Req, 0);
    RESET = 1;
    cyc(); #1;
    chk("seq_npc", bus.NPC, 32'h3004);
    chk("seq_we", bus.PC_WE, 1);
    chk("seq_flush", bus.flush_fd, 0);
    #1 RESET = 0; #1;
    chk("midrst_we", bus.PC_WE, 0);
    chk("midrst_pend", bus.pend_valid, 0);
    RESET = 1;
    cyc();
    bus.stall = 1; bus.br_valid = 1; bus.br_target = 32'h3040; #1;
    chk("stbr_we", bus.PC_WE, 0);
    chk("stbr_npc", bus.NPC, 32'h3004);
    cyc();
    bus.br_target = 32'h3080; #1;
    chk("stbr_pend", bus.pend_valid, 1);
    chk("stbr2_we", bus.PC_WE, 0);
    cyc();
    idle(); #1;
    chk("pend_npc", bus.NPC, 32'h3040);
    chk("pend_we", bus.PC_WE, 1);
    cyc(); #1;
    chk("pend_clr", bus.pend_valid, 0);
    chk("pend_seq", bus.NPC, 32'h3004);
    bus.stall = 1; bus.br_valid = 1; bus.br_target = 32'h3200;
    cyc(); #1;
    chk("exc_pre_pend", bus.pend_valid, 1);
    bus.exc_req = 1; #1;
    chk("exc_req", bus.Req, 1);
    chk("exc_npc", bus.NPC, 32'h4180);
    chk("exc_we", bus.PC_WE, 1);
    chk("exc_flush", bus.flush_fd, 1);
    cyc();
    idle(); bus.br_valid = 1; bus.br_target = 32'h3300; #1;
    chk("h1_busy", bus.busy, 1);
    chk("h1_we", bus.PC_WE, 0);
    chk("h1_flush", bus.flush_fd, 1);
    chk("h1_pend", bus.pend_valid, 0);
    chk("h1_npc", bus.NPC, 32'h3004);
    chk("h1_req", bus.Req, 0);
    cyc(); #1;
    chk("h2_busy", bus.busy, 1);
    chk("h2_we", bus.PC_WE, 0);
    cyc(); #1;
    chk("run_busy", bus.busy, 0);
    chk("run_br_npc", bus.NPC, 32'h3300);
    chk("run_br_we", bus.PC_WE, 1);
    idle(); bus.exc_req = 1; bus.eret_req = 1; #1;
    chk("excer_npc", bus.NPC, 32'h4180);
    chk("excer_req", bus.Req, 1);
    cyc();
    idle(); cyc(); cyc(); #1;
    chk("excer_run", bus.busy, 0);
    bus.eret_req = 1; #1;
    chk("eret_npc", bus.NPC, 32'h3100);
    chk("eret_flush", bus.flush_fd, 1);
    chk("eret_req", bus.Req, 0);
    chk("eret_we", bus.PC_WE, 1);
    cyc();
    idle(); bus.exc_req = 1;
    cyc();
    idle(); bus.eret_req = 1; #1;
    chk("rx_h1_busy", bus.busy, 1);
    chk("rx_h1_eret_we", bus.PC_WE, 0);
    chk("rx_h1_eret_npc", bus.NPC, 32'h3004);
    cyc();
    idle(); bus.exc_req = 1; #1;
    chk("rx_h2_req", bus.Req, 1);
    chk("rx_h2_we", bus.PC_WE, 1);
    chk("rx_h2_npc", bus.NPC, 32'h4180);
    chk("rx_h2_busy", bus.busy, 1);
    cyc();
    idle(); #1;
    chk("rx_h3_busy", bus.busy, 1);
    chk("rx_h3_we", bus.PC_WE, 0);
    cyc(); #1;
    chk("rx_h4_busy", bus.busy, 1);
    cyc(); #1;
    chk("rx_run_busy", bus.busy, 0);
    chk("rx_run_we", bus.PC_WE, 1);
    bus.F_PC = 32'hFFFF_FFFC; #1;
    chk("wrap_npc", bus.NPC, 32'h0000_0000);
    bus.F_PC = 32'h3000; bus.exc_req = 1;
    cyc();
    idle(); #1;
    chk("hrst_pre_busy", bus.busy, 1);
    RESET = 0; #1;
    chk("hrst_busy", bus.busy, 0);
    chk("hrst_flush", bus.flush_fd, 0);
    RESET = 1;
    cyc(); #1;
    chk("hrst_run_we", bus.PC_WE, 1);
    chk("hrst_run_busy", bus.busy, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
